hs_ifr_evt_detect: RTL and testbench
====================================

// Module: hs_ifr_evt_detect
// PURPOSE
// - Turns an asynchronous input into a clean synchronous event: N-flop synchronizer, glitch filter,
//   then edge or level detection selected by the shared misc typedefs.
// - Output is a one-cycle event strobe plus a sticky pending flag with clear.
// - Sits between raw pads / foreign-domain signals and interrupt or control logic.
// PARAMETERS
// SYNC_STAGES  2            synchronizer depth, legal >= 2
// FILT_CYCLES  4            consecutive stable cycles needed to accept a change; 1 = no filtering, legal >= 1
// DET_KIND     BOOL_TRUE    bool_e; BOOL_TRUE = edge mode, BOOL_FALSE = level mode
// EDGE_SEL     EDGE_POSEDGE edge_e; edges that fire in edge mode
// LEVEL_SEL    LEVEL_HIGH   level_e; active level in level mode; LEVEL_BOTH is an elaboration error
// RST_LEVEL    1'b0         reset value of the synchronizer flops and filt_o
// PORTS
// clk          in   1            single clock
// rst_n        in   1            asynchronous reset, active low
// en_i         in   1            detection enable
// async_i      in   1            asynchronous input
// clr_i        in   1            clears pend_o
// filt_o       out  1            synchronized, filtered level
// evt_o        out  1            event strobe (edge: 1-cycle pulse; level: high while active)
// pend_o       out  1            sticky pending flag
// BEHAVIOUR
// - Clocking: one clock; reset is asynchronous and active-low.
// - Reset values:
//   - sync chain = RST_LEVEL, filt_o = RST_LEVEL.
//   - Filter counter = 0, evt_o = 0, pend_o = 0.
//   - No event fires on reset release if async_i == RST_LEVEL.
// - Synchronizer: s_q = output of the SYNC_STAGES-deep chain.
//   - A change of async_i before edge 1 appears on s_q after edge SYNC_STAGES.
// - Filter: cnt is $clog2(FILT_CYCLES+1) bits wide and saturates logically (never wraps).
//   - At each edge with s_q != filt_o: if cnt == FILT_CYCLES-1, toggle filt_o and set cnt = 0; else cnt++.
//   - At each edge with s_q == filt_o: cnt = 0. Any reversion restarts the count.
//   - filt_o changes at edge SYNC_STAGES+FILT_CYCLES after the input change (defaults: edge 6).
// - Edge mode: evt_o registered; high for exactly the one cycle in which filt_o shows its new value.
//   - Fires only if the transition matches EDGE_SEL: POSEDGE 0->1, NEGEDGE 1->0, BOTH either.
// - Level mode: evt_o = registered (filt_o_next == LEVEL_SEL), so it is aligned with filt_o.
// - en_i = 0: evt_o forced 0 next cycle and pend_o not set. Sync and filter keep tracking.
//   - Re-enabling does not produce an edge from a change made while disabled.
//   - In level mode evt_o rises the cycle after en_i rises if the level is active.
// - pend_o: set in the cycle after evt_o would be 1 (same edge that registers evt_o);
//   cleared by clr_i sampled at an edge.
//   - Set and clear at the same edge: set wins, pend_o stays 1.
//   - Level mode: clr_i has no effect while the level is active.
// - Reset mid-operation: all state returns asynchronously to reset values; no partial event.
// - Unknowns on async_i are tolerated by the synchronizer; filt_o never goes X after reset.
// STRUCTURE
// - Uses bool_e, edge_e, level_e from hs_ifr_misc_typedefs_pkg. No new typedefs.
// - Add to that package: function automatic bit edge_match(edge_e sel, bit prev, bit nxt).
// - Sub-module hs_ifr_sync_cell (#STAGES, #RST_VAL): the synchronizer chain, reusable elsewhere.
// - Remainder (filter counter, detector, pending flop) lives in this module.
// TESTING
// 1. Reset, async_i = 0, defaults -> after reset: filt_o = 0, evt_o = 0, pend_o = 0 for 20 cycles.
// 2. async_i 0->1 before edge 1 -> filt_o = 1 at edge 6; evt_o = 1 for one cycle at edge 6;
//    pend_o = 1 from edge 6.
// 3. Glitch: async_i high for 3 cycles, then low -> filt_o, evt_o, pend_o stay 0;
//    a 4-cycle pulse -> evt_o fires.
// 4. EDGE_SEL = EDGE_BOTH: toggle async_i every 10 cycles, 4 times -> exactly 4 evt_o pulses
//    spaced 10 cycles apart.
// 5. pend_o = 1, clr_i = 1 on the same edge as a new evt_o -> pend_o stays 1;
//    clr_i alone next cycle -> pend_o = 0.
// 6. Level mode, LEVEL_LOW, RST_LEVEL = 1:
//    - async_i held 0 -> evt_o = 1 from edge 6; clr_i ignored.
//    - en_i = 0 -> evt_o = 0 next cycle.
//    - rst_n pulsed low mid-count -> all outputs 0 and filt_o = 1 immediately.

Source files
------------

// File: rtl/hs_ifr_misc_typedefs_pkg.sv
// rtl/hs_ifr_misc_typedefs_pkg.sv - shared misc typedefs and edge helper
package hs_ifr_misc_typedefs_pkg;

    typedef enum logic {
        BOOL_FALSE = 1'b0,
        BOOL_TRUE  = 1'b1
    } bool_e;

    typedef enum logic [1:0] {
        EDGE_POSEDGE = 2'd0,
        EDGE_NEGEDGE = 2'd1,
        EDGE_BOTH    = 2'd2
    } edge_e;

    typedef enum logic [1:0] {
        LEVEL_LOW  = 2'd0,
        LEVEL_HIGH = 2'd1,
        LEVEL_BOTH = 2'd2
    } level_e;

    // True when the transition prev -> nxt is one of the edges selected by sel.
    function automatic bit edge_match(edge_e sel, bit prev, bit nxt);
        bit hit;
        hit = 1'b0;
        case (sel)
            EDGE_POSEDGE: hit = !prev && nxt;
            EDGE_NEGEDGE: hit = prev && !nxt;
            EDGE_BOTH:    hit = prev != nxt;
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/hs_ifr_sync_cell.sv
// rtl/hs_ifr_sync_cell.sv - multi-flop synchronizer chain
module hs_ifr_sync_cell #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the raw input through the chain; bit 0 is the metastability-exposed flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/hs_ifr_evt_detect.sv
// rtl/hs_ifr_evt_detect.sv - synchronized, filtered edge/level event detector
module hs_ifr_evt_detect
    import hs_ifr_misc_typedefs_pkg::*;
#(
    parameter int     SYNC_STAGES = 2,
    parameter int     FILT_CYCLES = 4,
    parameter bool_e  DET_KIND    = BOOL_TRUE,
    parameter edge_e  EDGE_SEL    = EDGE_POSEDGE,
    parameter level_e LEVEL_SEL   = LEVEL_HIGH,
    parameter logic   RST_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic async_i,
    input  logic clr_i,
    output logic filt_o,
    output logic evt_o,
    output logic pend_o
);

    localparam int               CNT_W     = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FILT_CYCLES - 1);
    localparam logic             LEVEL_ACT = (LEVEL_SEL == LEVEL_HIGH);
    localparam bit               EDGE_MODE = (DET_KIND == BOOL_TRUE);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("hs_ifr_evt_detect: SYNC_STAGES must be >= 2");
    end
    if (FILT_CYCLES < 1) begin : g_bad_filt
        $error("hs_ifr_evt_detect: FILT_CYCLES must be >= 1");
    end
    if (LEVEL_SEL == LEVEL_BOTH) begin : g_bad_level
        $error("hs_ifr_evt_detect: LEVEL_BOTH is not a valid active level");
    end

    logic             s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             filt_q;
    logic             filt_d;
    logic             toggle;
    logic             level_on;
    logic             evt_d;
    logic             clr_ok;
    logic             pend_d;
    logic             evt_q;
    logic             pend_q;

    hs_ifr_sync_cell #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (async_i),
        .q_o   (s_q)
    );

    // Glitch filter: accept a new level only after FILT_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        toggle = 1'b0;
        if (s_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = ~filt_q;
                toggle = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Event and pending decisions, computed from the filter's next value so they align with filt_o.
    always_comb begin
        level_on = (filt_d == LEVEL_ACT);
        evt_d    = 1'b0;
        if (en_i) begin
            if (EDGE_MODE) begin
                evt_d = toggle && edge_match(EDGE_SEL, filt_q, filt_d);
            end else begin
                evt_d = level_on;
            end
        end
        // An active level keeps the request asserted, so a clear cannot retire it.
        clr_ok = clr_i && !(!EDGE_MODE && level_on);
        pend_d = pend_q;
        if (evt_d) begin
            pend_d = 1'b1;
        end else if (clr_ok) begin
            pend_d = 1'b0;
        end
    end

    // Filter, event and pending state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= RST_LEVEL;
            evt_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            evt_q  <= evt_d;
            pend_q <= pend_d;
        end
    end

    assign filt_o = filt_q;
    assign evt_o  = evt_q;
    assign pend_o = pend_q;

endmodule

// File: tb/tb_hs_ifr_evt_detect.sv
// tb/tb_hs_ifr_evt_detect.sv - randomized model-checked bench for hs_ifr_evt_detect
module tb_hs_ifr_evt_detect;
    import hs_ifr_misc_typedefs_pkg::*;

    localparam int ND   = 4;
    localparam int HMAX = 8192;

    // Per-instance configuration as the model sees it: 0 pos, 1 neg, 2 both.
    int sync_n  [ND] = '{2, 2, 2, 3};
    int filt_n  [ND] = '{4, 4, 4, 1};
    bit is_edge [ND] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int esel    [ND] = '{0, 2, 0, 1};
    bit lact    [ND] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit rstl    [ND] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic clk;
    logic rst_n;
    logic en_i;
    logic async_i;
    logic clr_i;
    logic [ND-1:0] filt_w;
    logic [ND-1:0] evt_w;
    logic [ND-1:0] pend_w;

    int checks = 0;
    int errors = 0;
    bit go     = 1'b0;

    hs_ifr_evt_detect u_dut0 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .async_i(async_i), .clr_i(clr_i),
        .filt_o(filt_w[0]), .evt_o(evt_w[0]), .pend_o(pend_w[0])
    );

    hs_ifr_evt_detect #(.EDGE_SEL(EDGE_BOTH)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .async_i(async_i), .clr_i(clr_i),
        .filt_o(filt_w[1]), .evt_o(evt_w[1]), .pend_o(pend_w[1])
    );

    hs_ifr_evt_detect #(.DET_KIND(BOOL_FALSE), .LEVEL_SEL(LEVEL_LOW), .RST_LEVEL(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .async_i(async_i), .clr_i(clr_i),
        .filt_o(filt_w[2]), .evt_o(evt_w[2]), .pend_o(pend_w[2])
    );

    hs_ifr_evt_detect #(.SYNC_STAGES(3), .FILT_CYCLES(1), .EDGE_SEL(EDGE_NEGEDGE)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .async_i(async_i), .clr_i(clr_i),
        .filt_o(filt_w[3]), .evt_o(evt_w[3]), .pend_o(pend_w[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: input history since reset; the filter accepts a level once the synchronized
    // view has disagreed with it on FILT consecutive edges since its last change.
    bit a_hist [0:HMAX-1];
    int k;
    bit m_filt [ND];
    bit m_evt  [ND];
    bit m_pend [ND];
    int m_last [ND];

    function automatic bit s_seen(int d, int e);
        if (e - sync_n[d] >= 1) return a_hist[e - sync_n[d]];
        return rstl[d];
    endfunction

    task automatic model_reset();
        k = 0;
        for (int d = 0; d < ND; d++) begin
            m_filt[d] = rstl[d];
            m_evt[d]  = 1'b0;
            m_pend[d] = 1'b0;
            m_last[d] = 0;
        end
    endtask

    task automatic model_step();
        k = k + 1;
        if (k < HMAX) a_hist[k] = async_i;
        for (int d = 0; d < ND; d++) begin
            bit tog;
            bit nf;
            bit hit;
            bit ev;
            tog = (k - filt_n[d]) >= m_last[d];
            for (int j = 0; j < filt_n[d]; j++) begin
                if (s_seen(d, k - j) == m_filt[d]) tog = 1'b0;
            end
            nf = tog ? !m_filt[d] : m_filt[d];
            if (tog) m_last[d] = k;
            if (is_edge[d]) hit = tog && (esel[d] == 2 || (esel[d] == 0 && nf) || (esel[d] == 1 && !nf));
            else            hit = (nf == lact[d]);
            ev = en_i && hit;
            if (ev) m_pend[d] = 1'b1;
            else if (clr_i && !(!is_edge[d] && nf == lact[d])) m_pend[d] = 1'b0;
            m_evt[d]  = ev;
            m_filt[d] = nf;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic chk(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Compare every instance against the model each cycle, between active edges.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (go) begin
                for (int d = 0; d < ND; d++) begin
                    chk($sformatf("model_filt%0d", d), filt_w[d], m_filt[d]);
                    chk($sformatf("model_evt%0d", d), evt_w[d], m_evt[d]);
                    chk($sformatf("model_pend%0d", d), pend_w[d], m_pend[d]);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset two cycles and release on a falling edge; the next rising edge is edge 1.
    task automatic reset_seq();
        rst_n   = 1'b0;
        async_i = 1'b0;
        clr_i   = 1'b0;
        en_i    = 1'b1;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses [$];
        int hold;
        rst_n   = 1'b0;
        async_i = 1'b0;
        en_i    = 1'b1;
        clr_i   = 1'b0;
        cyc(3);
        go = 1'b1;

        // Quiet input: nothing changes for 20 cycles.
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1); #1;
            chk("t1_filt0", filt_w[0], 1'b0);
            chk("t1_evt0", evt_w[0], 1'b0);
            chk("t1_pend0", pend_w[0], 1'b0);
        end

        // Rising input before edge 1 lands on filt_o at edge 6.
        reset_seq();
        async_i = 1'b1;
        cyc(5); #1;
        chk("t2_filt0_e5", filt_w[0], 1'b0);
        chk("t2_evt0_e5", evt_w[0], 1'b0);
        cyc(1); #1;
        chk("t2_filt0_e6", filt_w[0], 1'b1);
        chk("t2_evt0_e6", evt_w[0], 1'b1);
        chk("t2_pend0_e6", pend_w[0], 1'b1);
        cyc(1); #1;
        chk("t2_evt0_e7", evt_w[0], 1'b0);
        chk("t2_pend0_e7", pend_w[0], 1'b1);

        // Three-cycle glitch is rejected, four-cycle pulse is accepted.
        reset_seq();
        async_i = 1'b1;
        cyc(3);
        async_i = 1'b0;
        cyc(15); #1;
        chk("t3_glitch_filt0", filt_w[0], 1'b0);
        chk("t3_glitch_pend0", pend_w[0], 1'b0);
        async_i = 1'b1;
        cyc(4);
        async_i = 1'b0;
        cyc(15); #1;
        chk("t3_pulse_pend0", pend_w[0], 1'b1);

        // Both-edge instance: four toggles ten cycles apart give four pulses ten apart.
        reset_seq();
        pulses.delete();
        for (int i = 0; i < 4; i++) begin
            async_i = ~async_i;
            for (int c = 1; c <= 10; c++) begin
                cyc(1); #1;
                if (evt_w[1]) pulses.push_back(i * 10 + c);
            end
        end
        checks++;
        if (pulses.size() != 4) begin
            errors++;
            $display("FAIL t4_count: got %0d pulses expected 4", pulses.size());
        end else begin
            chk("t4_first_at_6", pulses[0] == 6, 1'b1);
            for (int i = 1; i < 4; i++) chk($sformatf("t4_spacing%0d", i), pulses[i] - pulses[i-1] == 10, 1'b1);
        end

        // Set and clear on the same edge: set wins; clear alone afterwards retires it.
        reset_seq();
        async_i = 1'b1;
        cyc(10);
        async_i = 1'b0;
        cyc(5);
        clr_i = 1'b1;
        cyc(1); #1;
        chk("t5_evt1_e16", evt_w[1], 1'b1);
        chk("t5_pend1_e16", pend_w[1], 1'b1);
        cyc(1); #1;
        chk("t5_pend1_e17", pend_w[1], 1'b0);
        clr_i = 1'b0;

        // Active-low level instance, reset level 1, input held low.
        reset_seq();
        cyc(5); #1;
        chk("t6_evt2_e5", evt_w[2], 1'b0);
        cyc(1); #1;
        chk("t6_evt2_e6", evt_w[2], 1'b1);
        chk("t6_filt2_e6", filt_w[2], 1'b0);
        clr_i = 1'b1;
        cyc(2); #1;
        chk("t6_pend2_clr_ignored", pend_w[2], 1'b1);
        clr_i = 1'b0;
        en_i  = 1'b0;
        cyc(1); #1;
        chk("t6_evt2_disabled", evt_w[2], 1'b0);
        en_i = 1'b1;
        cyc(1); #1;
        chk("t6_evt2_reenabled", evt_w[2], 1'b1);
        async_i = 1'b1;
        cyc(4);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_filt2", filt_w[2], 1'b1);
        chk("t6_rst_evt2", evt_w[2], 1'b0);
        chk("t6_rst_pend2", pend_w[2], 1'b0);
        chk("t6_rst_filt0", filt_w[0], 1'b0);

        // Randomized epochs, each ending in a mid-operation reset.
        for (int ep = 0; ep < 6; ep++) begin
            reset_seq();
            hold = 0;
            for (int c = 0; c < 1500; c++) begin
                if (hold == 0) begin
                    async_i = 1'($urandom_range(0, 1));
                    hold    = int'($urandom_range(1, 8));
                end
                hold--;
                en_i  = ($urandom_range(0, 9) != 0);
                clr_i = ($urandom_range(0, 5) == 0);
                cyc(1);
            end
            #3;
        end

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
